// File: rtl/ln_pkg.sv
// Shared constants and the requester tag type for the ln_fast_core front end.
package ln_pkg;

    localparam int LN_CORE_LATENCY = 75;
    localparam int LN_N_REQ        = 4;
    localparam int LN_ID_W         = $clog2(LN_N_REQ);

    localparam logic [31:0] ONE = 32'h3f80_0000;

    typedef struct packed {
        logic               valid;
        logic [LN_ID_W-1:0] id;
    } ln_tag_t;

endpackage

// File: rtl/ln_tag_delay.sv
// Tag delay line: carries {valid, requester id} alongside the core pipeline so
// the tail stage lines up with the core's done strobe.
module ln_tag_delay
    import ln_pkg::*;
#(
    parameter int LATENCY = LN_CORE_LATENCY
) (
    input  logic    clk,
    input  logic    rst,
    input  ln_tag_t tag_in,
    output ln_tag_t tag_out
);

    ln_tag_t stage_r [LATENCY];

    // Shift register; reset drops every in-flight tag so no stale response survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < LATENCY; k++) begin
                stage_r[k] <= '0;
            end
        end else begin
            stage_r[0] <= tag_in;
            for (int k = 1; k < LATENCY; k++) begin
                stage_r[k] <= stage_r[k-1];
            end
        end
    end

    assign tag_out = stage_r[LATENCY-1];

endmodule

// File: rtl/ln_core_arbiter.sv
// Round-robin front end sharing one fully pipelined ln_fast_core among N_REQ
// requesters, with per-requester outstanding caps and core reset sequencing.
module ln_core_arbiter
    import ln_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int LATENCY = LN_CORE_LATENCY,
    parameter int MAX_OUT = 8,
    parameter int ID_W    = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [32*N_REQ-1:0] req_x,
    output logic [N_REQ-1:0]    req_ready,
    output logic [N_REQ-1:0]    rsp_valid,
    output logic [ID_W-1:0]     rsp_id,
    output logic [31:0]         rsp_ln,
    output logic                rsp_error,
    output logic [31:0]         core_x,
    output logic                core_start,
    output logic                core_rst_n,
    input  logic [31:0]         core_ln,
    input  logic                core_done,
    input  logic                core_error,
    output logic                busy,
    output logic                sync_err
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t           state_r;
    logic             init_cnt_r;
    logic             core_rst_n_r;
    logic [ID_W-1:0]  rr_ptr_r;
    logic [CNT_W-1:0] out_cnt_r [N_REQ];
    logic             sync_err_r;

    logic [N_REQ-1:0] eligible_s;
    logic [N_REQ-1:0] grant_s;
    logic [ID_W-1:0]  grant_id_s;
    logic             xfer_s;
    logic [N_REQ-1:0] rsp_hit_s;
    logic             busy_s;
    ln_tag_t          tag_in_s;
    ln_tag_t          tail_s;

    // Eligibility uses the registered count, so a capped requester reopens one cycle after its response.
    always_comb begin
        eligible_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            eligible_s[i] = req_valid[i] && (out_cnt_r[i] < CNT_W'(MAX_OUT)) && (state_r == ST_RUN);
        end
    end

    // First eligible requester at or after rr_ptr wins.
    always_comb begin
        int               idx_v;
        logic [N_REQ-1:0] sel_v;
        logic             hit_v;
        grant_s    = '0;
        grant_id_s = '0;
        xfer_s     = 1'b0;
        idx_v      = 0;
        sel_v      = '0;
        hit_v      = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_v      = (int'(rr_ptr_r) + k) % N_REQ;
            sel_v      = eligible_s >> idx_v;
            hit_v      = !xfer_s && sel_v[0];
            grant_s    = hit_v ? ({{(N_REQ-1){1'b0}}, 1'b1} << idx_v) : grant_s;
            grant_id_s = hit_v ? ID_W'(idx_v) : grant_id_s;
            xfer_s     = xfer_s | hit_v;
        end
    end

    // Operand mux; grant is one-hot so OR-reduction selects the winner's slice.
    always_comb begin
        core_x = 32'h0000_0000;
        for (int i = 0; i < N_REQ; i++) begin
            core_x = core_x | ({32{grant_s[i]}} & req_x[32*i +: 32]);
        end
    end

    assign tag_in_s = '{valid: xfer_s, id: grant_id_s};

    ln_tag_delay #(
        .LATENCY (LATENCY)
    ) u_tag_delay (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in_s),
        .tag_out (tail_s)
    );

    assign rsp_hit_s = {{(N_REQ-1){1'b0}}, tail_s.valid} << tail_s.id;

    // Busy whenever any requester still has a result owed to it.
    always_comb begin
        busy_s = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            busy_s = busy_s | (out_cnt_r[i] != '0);
        end
    end

    // Core reset sequencer: hold the core in reset for two edges after rst releases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_INIT;
            init_cnt_r   <= 1'b0;
            core_rst_n_r <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    if (init_cnt_r) begin
                        state_r      <= ST_RUN;
                        core_rst_n_r <= 1'b1;
                    end else begin
                        init_cnt_r   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    core_rst_n_r <= 1'b1;
                end
                default: begin
                    state_r      <= ST_INIT;
                    init_cnt_r   <= 1'b0;
                    core_rst_n_r <= 1'b0;
                end
            endcase
        end
    end

    // Round-robin pointer advances past the winner only on a transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_r <= '0;
        end else if (xfer_s) begin
            rr_ptr_r <= (grant_id_s == ID_W'(N_REQ - 1)) ? '0 : grant_id_s + ID_W'(1);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Outstanding counters; simultaneous grant and response cancel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                out_cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                case ({grant_s[i], rsp_hit_s[i]})
                    2'b10:   out_cnt_r[i] <= out_cnt_r[i] + CNT_W'(1);
                    2'b01:   out_cnt_r[i] <= out_cnt_r[i] - CNT_W'(1);
                    default: out_cnt_r[i] <= out_cnt_r[i];
                endcase
            end
        end
    end

    // Sticky flag when the core's done strobe disagrees with the tag line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_err_r <= 1'b0;
        end else if ((state_r == ST_RUN) && (core_done != tail_s.valid)) begin
            sync_err_r <= 1'b1;
        end else begin
            sync_err_r <= sync_err_r;
        end
    end

    assign req_ready  = grant_s;
    assign core_start = xfer_s;
    assign core_rst_n = core_rst_n_r;
    assign rsp_valid  = rsp_hit_s;
    assign rsp_id     = tail_s.id;
    assign rsp_ln     = tail_s.valid ? core_ln : 32'h0000_0000;
    assign rsp_error  = tail_s.valid & core_error;
    assign busy       = busy_s;
    assign sync_err   = sync_err_r;

endmodule

// File: tb/tb_ln_core_arbiter.sv
// Directed bench for ln_core_arbiter with a behavioural 75-cycle core model
// and a response scoreboard.
module tb_ln_core_arbiter;

    localparam int N_REQ   = 4;
    localparam int LAT     = 75;
    localparam int MAX_OUT = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [3:0]    req_valid;
    logic [31:0]   xs [4];
    logic [127:0]  req_x;
    logic [3:0]    req_ready;
    logic [3:0]    rsp_valid;
    logic [1:0]    rsp_id;
    logic [31:0]   rsp_ln;
    logic          rsp_error;
    logic [31:0]   core_x;
    logic          core_start;
    logic          core_rst_n;
    logic [31:0]   core_ln;
    logic          core_done;
    logic          core_error;
    logic          busy;
    logic          sync_err;
    logic          inject_done = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    assign req_x = {xs[3], xs[2], xs[1], xs[0]};

    ln_core_arbiter #(
        .N_REQ   (N_REQ),
        .LATENCY (LAT),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_x      (req_x),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_ln     (rsp_ln),
        .rsp_error  (rsp_error),
        .core_x     (core_x),
        .core_start (core_start),
        .core_rst_n (core_rst_n),
        .core_ln    (core_ln),
        .core_done  (core_done),
        .core_error (core_error),
        .busy       (busy),
        .sync_err   (sync_err)
    );

    // ln(1+x) stand-in: exact value for 0.25, arbitrary but deterministic elsewhere.
    function automatic logic [31:0] ln_model(input logic [31:0] x);
        if (x == 32'h3e80_0000) return 32'h3e64_7fbe;
        return x ^ 32'h1234_5678;
    endfunction

    function automatic logic err_model(input logic [31:0] x);
        return x[30:0] > 31'h3f80_0000;
    endfunction

    // Core model: fixed-latency pipeline, synchronously cleared by core_rst_n.
    logic        pv   [LAT];
    logic [31:0] pln  [LAT];
    logic        perr [LAT];

    always @(posedge clk) begin
        if (!core_rst_n) begin
            for (int k = 0; k < LAT; k++) begin
                pv[k]   <= 1'b0;
                pln[k]  <= 32'h0;
                perr[k] <= 1'b0;
            end
        end else begin
            pv[0]   <= core_start;
            pln[0]  <= ln_model(core_x);
            perr[0] <= err_model(core_x);
            for (int k = 1; k < LAT; k++) begin
                pv[k]   <= pv[k-1];
                pln[k]  <= pln[k-1];
                perr[k] <= perr[k-1];
            end
        end
    end

    assign core_done  = pv[LAT-1] | inject_done;
    assign core_ln    = pln[LAT-1];
    assign core_error = perr[LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every observed transfer must come back exactly LAT cycles later.
    typedef struct {
        int          due;
        int          id;
        logic [31:0] x;
    } exp_t;

    exp_t sb [$];

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
            end else begin
                for (int i = 0; i < N_REQ; i++) begin
                    if (req_valid[i] && req_ready[i]) sb.push_back('{cyc + LAT, i, req_x[32*i +: 32]});
                end
                if (sb.size() > 0 && sb[0].due == cyc) begin
                    e = sb.pop_front();
                    chk("rsp_valid", 32'(rsp_valid), 32'(1) << e.id);
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    chk("rsp_ln", rsp_ln, ln_model(e.x));
                    chk("rsp_error", 32'(rsp_error), 32'(err_model(e.x)));
                end else if (rsp_valid != 4'b0000) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
                end
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply a request pattern and check the grant at the following negedge.
    task automatic arb_step(input string nm, input logic [3:0] v, input logic [3:0] exp);
        logic [31:0] xe;
        xe = 32'h0;
        req_valid = v;
        for (int i = 0; i < N_REQ; i++) begin
            if (exp[i]) xe = xs[i];
        end
        @(negedge clk);
        chk({nm, "_ready"}, 32'(req_ready), 32'(exp));
        chk({nm, "_start"}, 32'(core_start), 32'(|exp));
        chk({nm, "_x"}, core_x, xe);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        chk("rst_rsp_ln", rsp_ln, 32'h0);
        chk("rst_rsp_error", 32'(rsp_error), 32'h0);
        chk("rst_core_start", 32'(core_start), 32'h0);
        chk("rst_core_x", core_x, 32'h0);
        chk("rst_core_rst_n", 32'(core_rst_n), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_sync_err", 32'(sync_err), 32'h0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        req_valid = 4'b0000;
        repeat (80) tick();
        @(negedge clk);
        chk("drain_busy", 32'(busy), 32'h0);
        chk("drain_sb_empty", 32'(sb.size()), 32'h0);
        tick();
    endtask

    typedef struct packed {
        logic [3:0] valid;
        logic [3:0] ready;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{4'b1111, 4'b0001};
        tbl[1]  = '{4'b1111, 4'b0010};
        tbl[2]  = '{4'b0001, 4'b0001};
        tbl[3]  = '{4'b1000, 4'b1000};
        tbl[4]  = '{4'b0000, 4'b0000};
        tbl[5]  = '{4'b0110, 4'b0010};
        tbl[6]  = '{4'b0101, 4'b0100};
        tbl[7]  = '{4'b0011, 4'b0001};
        tbl[8]  = '{4'b1001, 4'b1000};
        tbl[9]  = '{4'b1110, 4'b0010};
        tbl[10] = '{4'b1011, 4'b1000};
        tbl[11] = '{4'b0100, 4'b0100};

        req_valid = 4'b1111;
        for (int i = 0; i < N_REQ; i++) xs[i] = 32'h3c00_0000 + 32'(i) * 32'h0008_0000;
        #2;
        tick();
        do_reset();

        // Reset release: two INIT cycles with the core held in reset.
        for (int c = 0; c < 2; c++) begin
            arb_step("init", 4'b1111, 4'b0000);
            chk("init_core_rst_n", 32'(core_rst_n), 32'h0);
            tick();
        end

        // Fairness: all valid, grants rotate 0,1,2,3 from cycle 2.
        for (int k = 0; k < 12; k++) begin
            arb_step("fair", 4'b1111, 4'(1) << (k % 4));
            chk("run_core_rst_n", 32'(core_rst_n), 32'h1);
            if (k > 0) chk("fair_busy", 32'(busy), 32'h1);
            tick();
        end
        req_valid = 4'b0000;
        for (int c = 14; c <= 88; c++) begin
            @(negedge clk);
            chk("fair_busy_hold", 32'(busy), 32'h1);
            tick();
        end
        @(negedge clk);
        chk("fair_busy_clear", 32'(busy), 32'h0);
        tick();

        // Single op from requester 1; rr_ptr is back at 0.
        xs[1] = 32'h3e80_0000;
        arb_step("single", 4'b0010, 4'b0010);
        tick();
        req_valid = 4'b0000;
        repeat (73) tick();
        @(negedge clk);
        chk("single_early", 32'(rsp_valid), 32'h0);
        tick();
        @(negedge clk);
        chk("single_valid", 32'(rsp_valid), 32'h2);
        chk("single_id", 32'(rsp_id), 32'h1);
        chk("single_ln", rsp_ln, 32'h3e64_7fbe);
        chk("single_err", 32'(rsp_error), 32'h0);
        tick();
        @(negedge clk);
        chk("single_once", 32'(rsp_valid), 32'h0);
        tick();

        // Error path: 2.0 flags an error, -0.5 does not.
        xs[0] = 32'h4000_0000;
        xs[3] = 32'hbf00_0000;
        arb_step("err0", 4'b0001, 4'b0001);
        tick();
        arb_step("err3", 4'b1000, 4'b1000);
        tick();
        req_valid = 4'b0000;
        repeat (73) tick();
        @(negedge clk);
        chk("err_big_valid", 32'(rsp_valid), 32'h1);
        chk("err_big_flag", 32'(rsp_error), 32'h1);
        tick();
        @(negedge clk);
        chk("err_neg_valid", 32'(rsp_valid), 32'h8);
        chk("err_neg_flag", 32'(rsp_error), 32'h0);
        tick();
        drain();

        // Table-driven arbitration from a fresh reset (rr_ptr = 0).
        req_valid = 4'b0000;
        do_reset();
        tick();
        tick();
        for (int i = 0; i < N_REQ; i++) xs[i] = 32'h3d00_0000 + 32'(i) * 32'h0010_0000;
        for (int t = 0; t < 12; t++) begin
            arb_step($sformatf("tbl%0d", t), tbl[t].valid, tbl[t].ready);
            tick();
        end
        drain();

        // Cap: requester 2 alone saturates at MAX_OUT and resumes after its first response.
        for (int c = 0; c <= 80; c++) begin
            arb_step("cap", 4'b0100, (c < MAX_OUT || c >= LAT + 1) ? 4'b0100 : 4'b0000);
            tick();
        end
        drain();

        // Reset with 30 ops in flight: nothing may come back.
        req_valid = 4'b1111;
        repeat (30) tick();
        @(negedge clk);
        chk("midrst_busy_before", 32'(busy), 32'h1);
        tick();
        req_valid = 4'b0000;
        do_reset();
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            chk("midrst_no_rsp", 32'(rsp_valid), 32'h0);
            tick();
        end
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_sync_err", 32'(sync_err), 32'h0);
        tick();

        // Spurious core_done: sticky sync_err, no response.
        inject_done = 1'b1;
        @(negedge clk);
        chk("spur_sync_err_pre", 32'(sync_err), 32'h0);
        chk("spur_no_rsp", 32'(rsp_valid), 32'h0);
        tick();
        inject_done = 1'b0;
        @(negedge clk);
        chk("spur_sync_err_set", 32'(sync_err), 32'h1);
        chk("spur_no_rsp_next", 32'(rsp_valid), 32'h0);
        tick();
        repeat (10) tick();
        @(negedge clk);
        chk("spur_sync_err_sticky", 32'(sync_err), 32'h1);
        tick();
        do_reset();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
